and_seq_driver: RTL and testbench
=================================

AND_SEQ_DRIVER -- requirements
Module: and_seq_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand and result width in bits.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15, setting the cycles between driving operands and sampling the result.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  the operand pair is offered.
REQ-006 in_ready  output  1  the block can accept an operand pair.
REQ-007 in_a, in_b  input  WIDTH each  offered operands.
REQ-008 drv_a, drv_b  output  WIDTH each  registered operands driven to the AND datapath's a and b ports.
REQ-009 dut_y  input  WIDTH  combinational result returned from the datapath's y port.
REQ-010 out_valid  output  1  the response is valid.
REQ-011 out_ready  input  1  the consumer accepts the response.
REQ-012 out_a, out_b, out_y  output  WIDTH each  echoed operands and the captured result.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SETTLE and RESP.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, when in_valid is 1 at a clock edge, the block SHALL:
- load drv_a and drv_b from in_a and in_b;
- load the settle counter with SETTLE_CYCLES-1;
- enter SETTLE.
REQ-016 In SETTLE the counter SHALL decrement each cycle.
REQ-017 On the edge where the SETTLE counter is 0, the block SHALL:
- capture dut_y into out_y;
- copy drv_a and drv_b into out_a and out_b;
- set out_valid to 1;
- enter RESP.
REQ-018 Latency: out_valid SHALL rise exactly SETTLE_CYCLES cycles after the acceptance edge.
REQ-019 In RESP, out_valid and out_a, out_b and out_y SHALL hold stable until out_ready is 1.
REQ-020 When out_ready is 1 in RESP, at that edge the block SHALL clear out_valid and return to IDLE; out_y, out_a and out_b hold their last values.
REQ-021 Throughput: at most one transaction per SETTLE_CYCLES+2 cycles; in_ready SHALL be 0 in SETTLE and RESP regardless of in_valid.
REQ-022 drv_a and drv_b SHALL hold their values between transactions and change only on acceptance.
REQ-023 out_ready while in IDLE or SETTLE SHALL have no effect.

Reset
REQ-024 While rst_n is 0, the following SHALL be 0 immediately and asynchronously: state (IDLE), counter, drv_a, drv_b, out_a, out_b, out_y, out_valid and all check outputs.
REQ-025 Reset mid-transaction SHALL abandon that transaction; no out_valid SHALL be produced for it after release.
REQ-026 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-027 The block SHALL compile its self-check logic only when the macro AND_SEQ_CHECK_EN is defined.
REQ-028 With AND_SEQ_CHECK_EN defined, the block SHALL add these outputs:
- mismatch  output  1: set together with out_valid when dut_y != (drv_a & drv_b), held with the response, cleared on the handshake;
- err_count  output  8: incremented on each mismatching capture, saturating at 255.
REQ-029 Without AND_SEQ_CHECK_EN, mismatch and err_count SHALL be absent and there SHALL be no related logic.

Structure
REQ-030 The shared package and_seq_pkg SHALL hold:
- the state enum (IDLE, SETTLE, RESP);
- the settle-counter width constant (4);
- the err_count width constant (8).
REQ-031 The check logic SHALL live in the sub-module and_seq_check, instantiated only under AND_SEQ_CHECK_EN.

Verification
REQ-032 The bench SHALL cover these directed scenarios (WIDTH=4, SETTLE_CYCLES=1, real AND datapath):
- in_a=0100, in_b=1100 -> out_y=0100, out_valid 1 cycle after acceptance.
- in_a=0110, in_b=1101 -> out_y=0100; out_a and out_b echo 0110 and 1101.
- out_ready held 0 for 5 cycles -> out_valid and out_y stable and in_ready=0 throughout; the response retires on the first out_ready=1 edge.
- rst_n pulsed low during SETTLE -> all outputs 0 at once, no out_valid after release, in_ready=1.
- SETTLE_CYCLES=3, in_a=1111, in_b=1010 -> out_valid exactly 3 cycles after acceptance, out_y=1010.
- AND_SEQ_CHECK_EN defined, dut_y forced to 0000 for in_a=1111, in_b=1111 -> mismatch=1 with out_valid and err_count=1; 300 repeated mismatches -> err_count=255.

Source files
------------

// File: rtl/and_seq_pkg.sv
// Shared types and widths for the AND-datapath sequencer and its optional checker.
package and_seq_pkg;

    localparam int unsigned CntWidth    = 4;
    localparam int unsigned ErrCntWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StResp
    } state_e;

endpackage

// File: rtl/and_seq_check.sv
// Compares the captured datapath result against drv_a & drv_b and counts mismatches.
// Instantiated by and_seq_driver only when AND_SEQ_CHECK_EN is defined.
module and_seq_check
    import and_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic                   retire,
    input  logic [WIDTH-1:0]       drv_a,
    input  logic [WIDTH-1:0]       drv_b,
    input  logic [WIDTH-1:0]       dut_y,
    output logic                   mismatch,
    output logic [ErrCntWidth-1:0] err_count
);

    logic                   mismatch_q, mismatch_d;
    logic [ErrCntWidth-1:0] err_q, err_d;
    logic                   bad;

    assign bad = (dut_y != (drv_a & drv_b));

    always_comb begin
        mismatch_d = mismatch_q;
        err_d      = err_q;
        if (capture) begin
            mismatch_d = bad;
            // Saturate rather than wrap so a long run of failures stays visible.
            if (bad && (err_q != '1)) begin
                err_d = err_q + ErrCntWidth'(1);
            end
        end else if (retire) begin
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_q;

endmodule

// File: rtl/and_seq_driver.sv
// Drives registered operands into an AND datapath, waits SETTLE_CYCLES, captures the result
// and offers it on a valid/ready response port. Optional self-check under AND_SEQ_CHECK_EN.
module and_seq_driver
    import and_seq_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       drv_a,
    output logic [WIDTH-1:0]       drv_b,
    input  logic [WIDTH-1:0]       dut_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    output logic [WIDTH-1:0]       out_y
`ifdef AND_SEQ_CHECK_EN
    ,
    output logic                   mismatch,
    output logic [ErrCntWidth-1:0] err_count
`endif
);

    // Counter holds the remaining settle cycles minus one; capture happens when it reads zero.
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    drv_a_q, drv_a_d;
    logic [WIDTH-1:0]    drv_b_q, drv_b_d;
    logic [WIDTH-1:0]    out_a_q, out_a_d;
    logic [WIDTH-1:0]    out_b_q, out_b_d;
    logic [WIDTH-1:0]    out_y_q, out_y_d;
    logic                out_valid_q, out_valid_d;
    logic                capture;
    logic                retire;

    assign capture = (state_q == StSettle) && (cnt_q == '0);
    assign retire  = (state_q == StResp) && out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drv_a_d     = drv_a_q;
        drv_b_d     = drv_b_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    drv_a_d = in_a;
                    drv_b_d = in_b;
                    cnt_d   = CntLoad;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (capture) begin
                    out_y_d     = dut_y;
                    out_a_d     = drv_a_q;
                    out_b_d     = drv_b_q;
                    out_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            StResp: begin
                if (retire) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drv_a_q     <= '0;
            drv_b_q     <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drv_a_q     <= drv_a_d;
            drv_b_q     <= drv_b_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign drv_a     = drv_a_q;
    assign drv_b     = drv_b_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;

`ifdef AND_SEQ_CHECK_EN
    and_seq_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .retire    (retire),
        .drv_a     (drv_a_q),
        .drv_b     (drv_b_q),
        .dut_y     (dut_y),
        .mismatch  (mismatch),
        .err_count (err_count)
    );
`endif

endmodule

// File: tb/tb_and_seq_driver.sv
// Directed bench for and_seq_driver: one instance with SETTLE_CYCLES=1, one with 3.
module tb_and_seq_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       force_zero;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_a, in_b, drv_a, drv_b, dut_y, out_a, out_b, out_y;

    logic       in_valid_3, in_ready_3, out_valid_3, out_ready_3;
    logic [3:0] in_a_3, in_b_3, drv_a_3, drv_b_3, dut_y_3, out_a_3, out_b_3, out_y_3;

`ifdef AND_SEQ_CHECK_EN
    logic       mismatch, mismatch_3;
    logic [7:0] err_count, err_count_3;
`endif

    int checks = 0;
    int errors = 0;

    assign dut_y   = force_zero ? 4'b0000 : (drv_a & drv_b);
    assign dut_y_3 = drv_a_3 & drv_b_3;

    and_seq_driver #(
        .WIDTH         (4),
        .SETTLE_CYCLES (1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .drv_a     (drv_a),
        .drv_b     (drv_b),
        .dut_y     (dut_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_y     (out_y)
`ifdef AND_SEQ_CHECK_EN
        ,
        .mismatch  (mismatch),
        .err_count (err_count)
`endif
    );

    and_seq_driver #(
        .WIDTH         (4),
        .SETTLE_CYCLES (3)
    ) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_3),
        .in_ready  (in_ready_3),
        .in_a      (in_a_3),
        .in_b      (in_b_3),
        .drv_a     (drv_a_3),
        .drv_b     (drv_b_3),
        .dut_y     (dut_y_3),
        .out_valid (out_valid_3),
        .out_ready (out_ready_3),
        .out_a     (out_a_3),
        .out_b     (out_b_3),
        .out_y     (out_y_3)
`ifdef AND_SEQ_CHECK_EN
        ,
        .mismatch  (mismatch_3),
        .err_count (err_count_3)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; force_zero = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_a = 4'd0; in_b = 4'd0;
        in_valid_3 = 1'b0; out_ready_3 = 1'b0; in_a_3 = 4'd0; in_b_3 = 4'd0;
        #2;
        checks++;
        if ({drv_a, drv_b, out_a, out_b, out_y, out_valid} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %b %b %b %b %b want all zero",
                     drv_a, drv_b, out_a, out_b, out_y, out_valid);
        end
        checks++;
        if (out_valid_3 !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid_3: got %b want 0", out_valid_3);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic(input logic [3:0] a, input logic [3:0] b, input logic [3:0] y);
        @(negedge clk); in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL basic_settle_flags: got valid=%b ready=%b want 0 0", out_valid, in_ready);
        end
        checks++;
        if ({drv_a, drv_b} !== {a, b}) begin
            errors++; $display("FAIL basic_drv: got %b %b want %b %b", drv_a, drv_b, a, b);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency: got out_valid=%b want 1", out_valid);
        end
        checks++;
        if (out_y !== y) begin
            errors++; $display("FAIL basic_out_y: got %b want %b", out_y, y);
        end
        checks++;
        if ({out_a, out_b} !== {a, b}) begin
            errors++; $display("FAIL basic_echo: got %b %b want %b %b", out_a, out_b, a, b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_retire: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        checks++;
        if ({out_y, out_a, out_b} !== {y, a, b}) begin
            errors++;
            $display("FAIL basic_hold_after_retire: got %b %b %b want %b %b %b",
                     out_y, out_a, out_b, y, a, b);
        end
    endtask

    task automatic test_hold();
        @(negedge clk); in_a = 4'b1001; in_b = 4'b0011; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        // Offer a new pair during RESP; it must not be taken.
        in_a = 4'b1111; in_b = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_y, drv_a} !== {1'b1, 1'b0, 4'b0001, 4'b1001}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b y=%b drv_a=%b want 1 0 0001 1001",
                         i, out_valid, in_ready, out_y, drv_a);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_retire: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); in_a = 4'b0111; in_b = 4'b0110; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({drv_a, drv_b, out_a, out_b, out_y, out_valid} !== 21'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b %b %b %b %b %b want all zero",
                     drv_a, drv_b, out_a, out_b, out_y, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL midreset_after%0d: got valid=%b ready=%b want 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_settle3();
        @(negedge clk); in_a_3 = 4'b1111; in_b_3 = 4'b1010; in_valid_3 = 1'b1;
        out_ready_3 = 1'b1;
        @(posedge clk); #1; in_valid_3 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (i < 3) begin
                if ({out_valid_3, in_ready_3} !== 2'b00) begin
                    errors++;
                    $display("FAIL settle3_early%0d: got valid=%b ready=%b want 0 0",
                             i, out_valid_3, in_ready_3);
                end
            end else begin
                if ({out_valid_3, out_y_3} !== {1'b1, 4'b1010}) begin
                    errors++;
                    $display("FAIL settle3_capture: got valid=%b y=%b want 1 1010",
                             out_valid_3, out_y_3);
                end
            end
        end
        @(posedge clk); #1; out_ready_3 = 1'b0;
        checks++;
        if ({out_valid_3, in_ready_3} !== 2'b01) begin
            errors++;
            $display("FAIL settle3_retire: got valid=%b ready=%b want 0 1", out_valid_3, in_ready_3);
        end
    endtask

`ifdef AND_SEQ_CHECK_EN
    task automatic test_check();
        force_zero = 1'b0;
        @(negedge clk); in_a = 4'b1111; in_b = 4'b1111; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mismatch, err_count} !== 9'd0) begin
            errors++;
            $display("FAIL check_good: got mismatch=%b err=%0d want 0 0", mismatch, err_count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        force_zero = 1'b1;
        @(negedge clk); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mismatch, out_valid, err_count} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL check_bad: got mismatch=%b valid=%b err=%0d want 1 1 1",
                     mismatch, out_valid, err_count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mismatch, err_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL check_clear: got mismatch=%b err=%0d want 0 1", mismatch, err_count);
        end
        // 299 more accept/capture/retire triples, three edges each.
        in_valid = 1'b1;
        for (int i = 0; i < 299 * 3; i++) begin
            @(posedge clk);
        end
        #1; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (err_count !== 8'd255) begin
            errors++; $display("FAIL check_saturate: got err=%0d want 255", err_count);
        end
        force_zero = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic(4'b0100, 4'b1100, 4'b0100);
        test_basic(4'b0110, 4'b1101, 4'b0100);
        test_hold();
        test_reset_mid();
        test_settle3();
`ifdef AND_SEQ_CHECK_EN
        test_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
